conv_acc_seq: RTL and testbench
===============================

// Module: conv_acc_seq
// PURPOSE
//  Parametrised KxK signed convolution accelerator, memory-mapped word-register slave.
//  Sequential MAC: one product per cycle, so multiplier area is independent of K.
//  Adds bias, arithmetic right-shift, saturation, optional ReLU, sticky status and an interrupt.
//  Sits on the CPU peripheral bus as the next generation of the conv accelerator.
// PARAMETERS
//  K       3   kernel/window side; N=K*K taps, 1<=N<=64
//  DATA_W  16  signed width of kernel/window/bias registers
//  ACC_W   40  signed accumulator width; must be >= 2*DATA_W+clog2(N)+1
//  OUT_W   32  signed width of RESULT after saturation (<=32)
//  ADDR_W  8   word-address width
// PORTS
//  clk     in   1       system clock
//  rst_n   in   1       asynchronous active-low reset
//  addr    in   ADDR_W  word address
//  en      in   1       bus access enable
//  we      in   1       1=write, 0=read
//  din     in   32      write data (low DATA_W bits used for data regs)
//  dout    out  32      read data, registered, valid 1 cycle after en&&!we
//  irq     out  1       level interrupt = done & irq_en
// BEHAVIOUR
//  Reset: async on rst_n=0; all regs, dout, irq, FSM=IDLE, acc, idx cleared to 0.
//  Map: 0x00 CTRL [0]start(W, self-clear, reads 0) [1]relu_en [2]irq_en [12:8]shift
//       0x01 STATUS [0]busy [1]done [2]ovf [3]err; done/ovf/err W1C
//       0x02 RESULT (OUT_W, sign-extended to 32), 0x03 BIAS, 0x04 CYCLES (last run length)
//       0x40+i KERNEL[i], 0x80+i WINDOW[i], i<N; unmapped read 0, write ignored.
//  Data regs read back sign-extended to 32; dout=0 in any cycle without a read.
//  FSM IDLE->RUN->FINISH->IDLE.
//   IDLE: write CTRL with din[0]=1 -> RUN; acc<=sext(BIAS), idx<=0,
//         done/ovf cleared, busy=1. CTRL bits [2:1],[12:8] latch on same write.
//   RUN: acc<=acc+WINDOW[idx]*KERNEL[idx] (signed, full ACC_W); idx++; after idx=N-1 -> FINISH.
//   FINISH: v=acc>>>shift (arith, floor); sat to OUT_W range, ovf=1 if clipped;
//           relu_en && v<0 -> 0 (ovf unaffected); RESULT<=v; done=1; busy=0; CYCLES<=N+1 -> IDLE.
//  Latency: start captured at edge T; done/RESULT visible at edge T+N+1 (K=3: T+10).
//  Busy rule: while busy, writes to CTRL/BIAS/KERNEL/WINDOW ignored and err<=1;
//   STATUS W1C still honoured; reads always allowed (live values).
//  Simultaneous: done set in FINISH beats W1C of done in same cycle; start with
//   din[0]=0 only updates mode bits; W1C mask 0 changes nothing.
//  irq combinational from registered done & irq_en; deasserts the cycle after done W1C.
//  Reset mid-RUN: aborts immediately, RESULT=0, no done.
// STRUCTURE
//  Package conv_acc_pkg: register offsets, CTRL/STATUS bit indices, FSM state encoding.
//  Sub-module conv_mac_unit: signed mult + ACC_W accumulate, shift, saturate, ReLU
//   (datapath only); top holds register file, bus decode and FSM.
// TESTING
//  1 K=3, KERNEL all 1, WINDOW 1..9, BIAS 0, shift 0, start -> done at T+10, RESULT=45, CYCLES=10.
//  2 KERNEL all -1, WINDOW 1..9, BIAS 5 -> RESULT=-40 (0xFFFFFFD8); rerun relu_en=1 -> 0, ovf=0.
//  3 shift=2, sum 45 -> 11; sum -45 -> -12 (floor).
//  4 OUT_W=16, KERNEL/WINDOW all 0x7FFF -> RESULT=0x00007FFF, ovf=1; W1C 0x4 clears ovf.
//  5 Write KERNEL[0] and CTRL start during RUN -> ignored, err=1, RESULT unchanged vs golden;
//    irq_en=1 -> irq high after done, low cycle after W1C 0x2.
//  6 rst_n low at RUN idx=4 -> all regs 0, busy=0, done=0, irq=0; fresh run gives correct result.

Source files
------------

// File: rtl/conv_acc_pkg.sv
// Shared definitions for the sequential convolution accelerator:
// register word offsets, CTRL/STATUS bit positions and FSM encoding.
package conv_acc_pkg;

    // Word offsets of the register map (compared after resizing to ADDR_W)
    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_STATUS      = 8'h01;
    localparam logic [7:0] REG_RESULT      = 8'h02;
    localparam logic [7:0] REG_BIAS        = 8'h03;
    localparam logic [7:0] REG_CYCLES      = 8'h04;
    localparam logic [7:0] REG_KERNEL_BASE = 8'h40;
    localparam logic [7:0] REG_WINDOW_BASE = 8'h80;

    // CTRL bit positions
    localparam int CTRL_START    = 0;
    localparam int CTRL_RELU     = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_SHIFT_LO = 8;
    localparam int CTRL_SHIFT_HI = 12;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_ERR  = 3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } conv_state_e;

endpackage

// File: rtl/conv_acc_seq_if.sv
// Word-register peripheral bus between the CPU and the accelerator.
// Access semantics: en qualifies a single-cycle access in the cycle it is
// high (we=1 write of din, we=0 read); there is no backpressure, every
// access completes in that cycle, and read data appears on dout one cycle
// later (dout is 0 in every cycle that follows a non-read). irq is a level.
interface conv_acc_seq_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              we;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic              irq;

    modport master (output addr, en, we, din, input dout, irq);
    modport slave  (input addr, en, we, din, output dout, irq);
endinterface

// File: rtl/conv_mac_unit.sv
// Datapath of the accelerator: one signed multiply-accumulate per cycle,
// plus the post-processing applied to the final sum (arithmetic shift,
// saturation to OUT_W, optional ReLU). Purely combinational.
module conv_mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32
) (
    input  logic signed [DATA_W-1:0] win,
    input  logic signed [DATA_W-1:0] ker,
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic        [4:0]        shift,
    input  logic                     relu_en,
    output logic signed [ACC_W-1:0]  acc_sum,
    output logic signed [OUT_W-1:0]  res,
    output logic                     clip
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;

    // Full-precision product, sign-extended into the accumulator width
    always_comb begin
        prod    = win * ker;
        acc_sum = acc_in + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    // Floor shift, clip to the OUT_W range, then ReLU on the clipped value
    always_comb begin
        shifted = acc_in >>> shift;
        clip    = 1'b0;
        if (shifted > SAT_MAX) begin
            res  = OUT_MAX;
            clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res  = OUT_MIN;
            clip = 1'b1;
        end else begin
            res = shifted[OUT_W-1:0];
        end
        if (relu_en && res[OUT_W-1]) begin
            res = '0;
        end
    end

endmodule

// File: rtl/conv_acc_seq.sv
// KxK signed convolution accelerator on the word-register bus.
// Holds the register file, bus decode and the IDLE->RUN->FINISH sequencer;
// the arithmetic lives in conv_mac_unit. One tap is accumulated per cycle.
module conv_acc_seq
    import conv_acc_pkg::*;
#(
    parameter int K      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    conv_acc_seq_if.slave   bus,
    output conv_state_e     dbg_state
);

    localparam int N     = K * K;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] RUN_CYCLES = 32'(N + 1);

    // Configuration and data registers
    logic                     relu_en_q;
    logic                     irq_en_q;
    logic [4:0]               shift_q;
    logic signed [DATA_W-1:0] bias_q;
    logic signed [DATA_W-1:0] kernel_q [N];
    logic signed [DATA_W-1:0] window_q [N];

    // Run state and results
    conv_state_e              state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [OUT_W-1:0]  result_q;
    logic [31:0]              cycles_q;
    logic                     done_q, ovf_q, err_q;
    logic                     done_d, ovf_d, err_d;

    // Datapath outputs
    logic signed [ACC_W-1:0]  mac_acc_sum;
    logic signed [OUT_W-1:0]  mac_res;
    logic                     mac_clip;

    // Bus decode
    logic              wr, rd, busy;
    logic              hit_ctrl, hit_status, hit_result, hit_bias, hit_cycles;
    logic              hit_kernel, hit_window;
    logic [IDX_W-1:0]  kernel_sel, window_sel;
    logic              data_wr, start_go, status_w1c;
    logic [31:0]       rdata;
    logic              unused_din;

    assign wr   = bus.en & bus.we;
    assign rd   = bus.en & ~bus.we;
    assign busy = (state_q != ST_IDLE);

    assign hit_ctrl   = (bus.addr == ADDR_W'(REG_CTRL));
    assign hit_status = (bus.addr == ADDR_W'(REG_STATUS));
    assign hit_result = (bus.addr == ADDR_W'(REG_RESULT));
    assign hit_bias   = (bus.addr == ADDR_W'(REG_BIAS));
    assign hit_cycles = (bus.addr == ADDR_W'(REG_CYCLES));
    assign hit_kernel = (bus.addr >= ADDR_W'(REG_KERNEL_BASE)) &&
                        (bus.addr <  ADDR_W'(REG_KERNEL_BASE) + ADDR_W'(N));
    assign hit_window = (bus.addr >= ADDR_W'(REG_WINDOW_BASE)) &&
                        (bus.addr <  ADDR_W'(REG_WINDOW_BASE) + ADDR_W'(N));
    assign kernel_sel = IDX_W'(bus.addr - ADDR_W'(REG_KERNEL_BASE));
    assign window_sel = IDX_W'(bus.addr - ADDR_W'(REG_WINDOW_BASE));

    // Writes to the run-time configuration are only legal while idle
    assign data_wr    = wr & (hit_ctrl | hit_bias | hit_kernel | hit_window);
    assign start_go   = !busy && wr && hit_ctrl && bus.din[CTRL_START];
    assign status_w1c = wr & hit_status;

    // Only the low DATA_W / field bits of din are meaningful
    assign unused_din = ^bus.din;

    assign bus.irq   = done_q & irq_en_q;
    assign dbg_state = state_q;

    conv_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .win     (window_q[idx_q]),
        .ker     (kernel_q[idx_q]),
        .acc_in  (acc_q),
        .shift   (shift_q),
        .relu_en (relu_en_q),
        .acc_sum (mac_acc_sum),
        .res     (mac_res),
        .clip    (mac_clip)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Sequencer next state: start in IDLE, N accumulate cycles, one finish cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_go) state_d = ST_RUN;
            ST_RUN:    if (idx_q == IDX_W'(N - 1)) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sticky status next value; a finishing run wins over a same-cycle W1C
    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        if (status_w1c) begin
            if (bus.din[STAT_DONE]) done_d = 1'b0;
            if (bus.din[STAT_OVF])  ovf_d  = 1'b0;
            if (bus.din[STAT_ERR])  err_d  = 1'b0;
        end
        if (busy && data_wr) err_d = 1'b1;
        if (start_go) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (state_q == ST_FINISH) begin
            done_d = 1'b1;
            if (mac_clip) ovf_d = 1'b1;
        end
    end

    // Host-writable configuration and operand registers (idle only)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu_en_q <= 1'b0;
            irq_en_q  <= 1'b0;
            shift_q   <= '0;
            bias_q    <= '0;
            for (int i = 0; i < N; i++) begin
                kernel_q[i] <= '0;
                window_q[i] <= '0;
            end
        end else if (wr && !busy) begin
            if (hit_ctrl) begin
                relu_en_q <= bus.din[CTRL_RELU];
                irq_en_q  <= bus.din[CTRL_IRQ_EN];
                shift_q   <= bus.din[CTRL_SHIFT_HI:CTRL_SHIFT_LO];
            end
            if (hit_bias)   bias_q               <= bus.din[DATA_W-1:0];
            if (hit_kernel) kernel_q[kernel_sel] <= bus.din[DATA_W-1:0];
            if (hit_window) window_q[window_sel] <= bus.din[DATA_W-1:0];
        end
    end

    // Accumulator, tap index, result capture and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        acc_q <= ACC_W'(bias_q);
                        idx_q <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q <= mac_acc_sum;
                    idx_q <= idx_q + 1'b1;
                end
                ST_FINISH: begin
                    result_q <= mac_res;
                    cycles_q <= RUN_CYCLES;
                end
                default: ;
            endcase
        end
    end

    // Read mux: live register values, data registers sign-extended
    always_comb begin
        rdata = '0;
        if (hit_ctrl) begin
            rdata[CTRL_RELU]                    = relu_en_q;
            rdata[CTRL_IRQ_EN]                  = irq_en_q;
            rdata[CTRL_SHIFT_HI:CTRL_SHIFT_LO]  = shift_q;
        end else if (hit_status) begin
            rdata[STAT_BUSY] = busy;
            rdata[STAT_DONE] = done_q;
            rdata[STAT_OVF]  = ovf_q;
            rdata[STAT_ERR]  = err_q;
        end else if (hit_result) begin
            rdata = 32'(result_q);
        end else if (hit_bias) begin
            rdata = 32'(bias_q);
        end else if (hit_cycles) begin
            rdata = cycles_q;
        end else if (hit_kernel) begin
            rdata = 32'(kernel_q[kernel_sel]);
        end else if (hit_window) begin
            rdata = 32'(window_q[window_sel]);
        end
    end

    // Registered read data, zero in any cycle that did not follow a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  bus.dout <= '0;
        else if (rd) bus.dout <= rdata;
        else         bus.dout <= '0;
    end

endmodule

// File: tb/tb_conv_acc_seq.sv
// Self-checking bench for conv_acc_seq (K=3, OUT_W=16 so saturation is reachable).
module tb_conv_acc_seq;
  import conv_acc_pkg::*;

  localparam int K      = 3;
  localparam int N      = K * K;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_acc_seq_if #(.ADDR_W(ADDR_W)) bus ();
  conv_state_e dbg_state;

  conv_acc_seq #(
    .K(K), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int kern[N];
  int win[N];
  int bias;
  int unsigned t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.din = d; bus.we = 1'b1; bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.we = 1'b0; bus.en = 1'b1;
    @(posedge clk); #1;
    d = bus.dout;
    bus.en = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic load_regs();
    for (int i = 0; i < N; i++) begin
      bus_write(REG_KERNEL_BASE + 8'(i), 32'(kern[i]));
      bus_write(REG_WINDOW_BASE + 8'(i), 32'(win[i]));
    end
    bus_write(REG_BIAS, 32'(bias));
  endtask

  // Reference: bias + sum(k*w), floor shift, clip to OUT_W, ReLU
  function automatic logic [31:0] model(input int sh, input bit relu, output bit ovf);
    longint s;
    longint mx;
    s = longint'(bias);
    for (int i = 0; i < N; i++) s += longint'(kern[i]) * longint'(win[i]);
    s = s >>> sh;
    mx = (64'sd1 <<< (OUT_W - 1)) - 1;
    ovf = 1'b0;
    if (s > mx) begin s = mx; ovf = 1'b1; end
    else if (s < -mx - 1) begin s = -mx - 1; ovf = 1'b1; end
    if (relu && s < 0) s = 0;
    return 32'(s);
  endfunction

  // Push expected RESULT and STATUS, then issue start with irq_en set
  task automatic start_run(input int sh, input bit relu, input bit err_exp);
    bit ovf;
    logic [31:0] r;
    r = model(sh, relu, ovf);
    exp_q.push_back(r);
    exp_q.push_back({28'd0, err_exp, ovf, 1'b1, 1'b0});
    bus_write(REG_CTRL, (32'(sh) << 8) | 32'h4 | (32'(relu) << 1) | 32'h1);
    t0 = cyc;
  endtask

  // Wait (bounded) for irq, then compare latency, RESULT, STATUS, CYCLES
  task automatic finish_run(input string tag);
    int n;
    logic [31:0] v;
    n = 0;
    while (!bus.irq && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.irq) check({tag, "_timeout"}, 32'd0, 32'd1);
    else          check({tag, "_lat"}, 32'(cyc - t0), 32'(N + 1));
    bus_read(REG_RESULT, v);
    check({tag, "_result"}, v, exp_q.pop_front());
    bus_read(REG_STATUS, v);
    check({tag, "_status"}, v, exp_q.pop_front());
    check_reg({tag, "_cycles"}, REG_CYCLES, 32'(N + 1));
  endtask

  task automatic set_ramp(input int kval, input int b);
    for (int i = 0; i < N; i++) begin
      kern[i] = kval;
      win[i]  = i + 1;
    end
    bias = b;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] v;
    bus.addr = '0; bus.en = 1'b0; bus.we = 1'b0; bus.din = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check_reg("rst_status", REG_STATUS, 32'd0);
    check_reg("rst_result", REG_RESULT, 32'd0);
    check_reg("rst_ctrl", REG_CTRL, 32'd0);
    check_reg("unmapped", 8'h05, 32'd0);

    // Mode bits without start: only CTRL fields change
    bus_write(REG_CTRL, 32'h0000_0306);
    check("dout_idle", bus.dout, 32'd0);
    check_reg("mode_ctrl", REG_CTRL, 32'h0000_0306);
    check_reg("mode_status", REG_STATUS, 32'd0);

    // 1: ramp window, unit kernel -> 45
    set_ramp(1, 0);
    load_regs();
    check_reg("win_rd", REG_WINDOW_BASE + 8'd8, 32'd9);
    start_run(0, 1'b0, 1'b0);
    finish_run("t1");

    // 2: negative kernel with bias -> -40, then ReLU -> 0
    set_ramp(-1, 5);
    load_regs();
    check_reg("kern_rd", REG_KERNEL_BASE, 32'hFFFF_FFFF);
    check_reg("bias_rd", REG_BIAS, 32'd5);
    start_run(0, 1'b0, 1'b0);
    finish_run("t2");
    start_run(0, 1'b1, 1'b0);
    finish_run("t2relu");

    // 3: floor shift of +45 and -45
    set_ramp(1, 0);
    load_regs();
    start_run(2, 1'b0, 1'b0);
    finish_run("t3pos");
    set_ramp(-1, 0);
    load_regs();
    start_run(2, 1'b0, 1'b0);
    finish_run("t3neg");

    // 4: saturation of large positive sum, then W1C behaviour
    for (int i = 0; i < N; i++) begin kern[i] = 32767; win[i] = 32767; end
    bias = 0;
    load_regs();
    start_run(0, 1'b0, 1'b0);
    finish_run("t4");
    bus_write(REG_STATUS, 32'h0);
    check_reg("w1c_zero", REG_STATUS, 32'h6);
    bus_write(REG_STATUS, 32'h4);
    check_reg("w1c_ovf", REG_STATUS, 32'h2);

    // Random small operands, shifts and ReLU
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        kern[i] = int'($urandom_range(0, 400)) - 200;
        win[i]  = int'($urandom_range(0, 400)) - 200;
      end
      bias = int'($urandom_range(0, 2000)) - 1000;
      load_regs();
      start_run(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
      finish_run($sformatf("rnd%0d", r));
    end

    // 5: writes during RUN are ignored and flag err; irq follows done
    for (int i = 0; i < N; i++) begin
      kern[i] = int'($urandom_range(0, 20)) - 10;
      win[i]  = int'($urandom_range(0, 20)) - 10;
    end
    bias = 3;
    load_regs();
    start_run(0, 1'b0, 1'b1);
    check_reg("t5_busy", REG_STATUS, 32'h1);
    bus_write(REG_KERNEL_BASE, 32'd99);
    bus_write(REG_CTRL, 32'h0000_0003);
    finish_run("t5");
    check("t5_irq_hi", 32'(bus.irq), 32'd1);
    check_reg("t5_kern0", REG_KERNEL_BASE, 32'(kern[0]));
    check_reg("t5_ctrl", REG_CTRL, 32'h4);
    bus_write(REG_STATUS, 32'h2);
    check("t5_irq_lo", 32'(bus.irq), 32'd0);
    bus_write(REG_STATUS, 32'h8);
    check_reg("t5_err_clr", REG_STATUS, 32'd0);

    // 6: asynchronous reset while idx=4 aborts the run
    set_ramp(2, 1);
    load_regs();
    start_run(0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_irq", 32'(bus.irq), 32'd0);
    check("t6_dout", bus.dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_reg("t6_status", REG_STATUS, 32'd0);
    check_reg("t6_result", REG_RESULT, 32'd0);
    check_reg("t6_cycles", REG_CYCLES, 32'd0);
    check_reg("t6_kern0", REG_KERNEL_BASE, 32'd0);
    check_reg("t6_bias", REG_BIAS, 32'd0);
    set_ramp(1, 0);
    load_regs();
    start_run(0, 1'b0, 1'b0);
    finish_run("t6fresh");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
